seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
- Programmable serial pattern-detection controller for the bit-serial sequence-detector datapath.
- Loads a pattern of 1..MAX_LEN bits and a mode (overlapping or non-overlapping).
- Arms and runs detection on a qualified serial stream, counts matches, and stops after a programmed match limit.
- Sits between a host/config master and the serial input. Generalises the fixed-pattern detector (e.g. 11001) into a sequenced, reconfigurable resource.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits.
- LEN_W, 4, width of the length field; must hold MAX_LEN.
- CNT_W, 8, width of the match counter and limit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accepted when cfg_valid&cfg_ready; equals (state!=RUN).
- cfg_pattern  input  MAX_LEN  pattern; bit[cfg_len-1] is first bit received, bit[0] is last.
- cfg_len  input  LEN_W  pattern length, legal range 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- cfg_limit  input  CNT_W  matches before auto-stop; 0 = unlimited.
- cfg_err  output  1  one-cycle pulse: illegal cfg_len handshaked.
- start  input  1  begin a run (honoured in ARMED or DONE).
- abort  input  1  stop a run (honoured in RUN).
- din  input  1  serial data bit.
- din_valid  input  1  din qualifier; bits with din_valid=0 are ignored.
- detect  output  1  match indication (Mealy; see Behaviour).
- match_count  output  CNT_W  matches in current/last run.
- busy  output  1  state==RUN.
- done  output  1  state==DONE (level).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; pattern/len/overlap/limit registers, history shift register, fill counter and match_count cleared. Outputs during reset: detect=0, busy=0, done=0, cfg_err=0, cfg_ready=1.
- States: IDLE, ARMED, RUN, DONE.
- Config handshake:
  - Legal length (1<=cfg_len<=MAX_LEN): registers loaded; IDLE/ARMED/DONE -> ARMED; match_count untouched.
  - Illegal length (0 or >MAX_LEN): cfg_err=1 for one cycle; registers and state unchanged.
- start in ARMED or DONE -> RUN next cycle; clears history, fill counter and match_count. start ignored in IDLE and RUN.
- RUN, per bit with din_valid=1:
  - history <= {history[MAX_LEN-2:0], din}.
  - fill counter increments, saturating at MAX_LEN.
- Match condition (combinational): state==RUN & din_valid & fill>=len-1 & {history,din} low len bits == pattern low len bits.
- detect = match condition, combinational from din in the same cycle (Mealy). Zero latency; high for exactly one cycle per matching bit.
- On match:
  - match_count increments, saturating at all-ones.
  - overlap=0: fill counter reset to 0, so the next match must use only bits after the current one.
  - overlap=1: history and fill are kept.
- Limit: if limit!=0 and a match makes match_count==limit, the matching bit still asserts detect and counts; RUN -> DONE next cycle.
- abort in RUN -> ARMED next cycle; config kept, match_count held. If abort and a limit-reaching match occur in the same cycle, abort wins: state -> ARMED, but detect and the count still occur for that bit.
- start and cfg handshake in the same cycle (ARMED/DONE): config loads and state -> RUN using the new config. Count and history are cleared.
- reset mid-run: immediate return to IDLE; all state lost.

Optional Feature:
- Macro DETECT_REG_EN.
- Defined: detect is registered, asserting one cycle after the matching bit (Moore-style timing). Count/limit timing is unchanged. The registered detect clears to 0 on reset and on abort.
- Undefined: combinational Mealy detect as above.

Test Plan:
- Reset then cfg pattern=8'b00011001, len=5, overlap=1, limit=0; start. Stream 0,1,1,0,0,1,1,0,0,1,0,1,1,0,0,1 (one bit per clk, din_valid=1) -> detect on bits 6, 10 and 16; match_count=3; busy=1 throughout.
- Same stream with overlap=0 -> detect on bits 6 and 16 only; match_count=2.
- overlap=1, limit=2, same stream -> detect on bits 6 and 10; done=1 the cycle after bit 10; bit 16 produces no detect; match_count stays 2.
- cfg_len=0, then cfg_len=9 -> cfg_err pulses once for each; state stays IDLE; cfg_ready stays 1.
- In RUN, hold din_valid=0 with din toggling, then abort at the same cycle as the final matching bit -> no detects while din_valid=0; the final bit detects and counts; state=ARMED; done=0.
- Drive reset=0 asynchronously mid-run, between clock edges -> busy, detect and match_count go to 0 immediately; state=IDLE.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Configuration channel between a host/config master and the sequence detector.
// Carries the pattern, length, overlap mode and match limit with a valid/ready handshake.
// The slave reports an illegal length through a one-cycle error pulse.
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_limit;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: IDLE/ARMED/RUN/DONE controller with match counting and limit.
// Latency: detect is combinational from din (zero cycles); with DETECT_REG_EN defined it is registered (one cycle).
// Backpressure: cfg_ready drops while RUN, so configuration is only accepted outside a run.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  seq_detect_ctrl_if.slave cfg,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LEN_W:0] FILL_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [1:0]         state;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic [CNT_W-1:0]   limit;
  logic [MAX_LEN-2:0] history;
  logic [LEN_W-1:0]   fill;

  logic               cfg_hs;
  logic               len_ok;
  logic               cfg_load;
  logic               start_go;
  logic               abort_go;
  logic [MAX_LEN-1:0] window;
  logic               pat_eq;
  logic               fill_ok;
  logic               match;
  logic [CNT_W-1:0]   cnt_next;
  logic               limit_hit;
  logic [LEN_W-1:0]   fill_inc;

  assign cfg_hs    = cfg.cfg_valid & cfg.cfg_ready;
  assign len_ok    = (cfg.cfg_len != '0) && (cfg.cfg_len <= FILL_MAX);
  assign cfg_load  = cfg_hs & len_ok;
  assign cfg.cfg_ready = (state != S_RUN);
  // Gated by reset so the error strobe is quiet while the block is held in reset.
  assign cfg.cfg_err   = cfg_hs & ~len_ok & reset;

  assign start_go = start & ((state == S_ARMED) | (state == S_DONE));
  assign abort_go = abort & (state == S_RUN);

  // Newest bit sits at window[0], matching pattern[0] as the last bit of the sequence.
  assign window = {history, din};

  // Compare only the low len bits of the window against the pattern.
  always_comb begin
    pat_eq = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(len)) && (window[i] != pattern[i])) pat_eq = 1'b0;
    end
  end

  // Enough history is present once fill + current bit covers the pattern length.
  assign fill_ok   = ({1'b0, fill} + FILL_ONE) >= {1'b0, len};
  assign match     = (state == S_RUN) & din_valid & fill_ok & pat_eq;
  assign cnt_next  = (&match_count) ? match_count : match_count + CNT_W'(1);
  assign limit_hit = match & (limit != '0) & (cnt_next == limit);
  assign fill_inc  = (fill == FILL_MAX) ? fill : fill + LEN_W'(1);

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Controller state: abort beats a limit-reaching match, start beats a plain config load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_RUN: begin
          if (abort_go)       state <= S_ARMED;
          else if (limit_hit) state <= S_DONE;
        end
        default: begin
          if (start_go)      state <= S_RUN;
          else if (cfg_load) state <= S_ARMED;
        end
      endcase
    end
  end

  // Configuration registers load only on a handshake with a legal length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern <= '0;
      len     <= '0;
      overlap <= 1'b0;
      limit   <= '0;
    end else if (cfg_load) begin
      pattern <= cfg.cfg_pattern;
      len     <= cfg.cfg_len;
      overlap <= cfg.cfg_overlap;
      limit   <= cfg.cfg_limit;
    end
  end

  // Serial history, fill level and match counter; non-overlap restarts the fill after a match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history     <= '0;
      fill        <= '0;
      match_count <= '0;
    end else if (start_go) begin
      history     <= '0;
      fill        <= '0;
      match_count <= '0;
    end else if ((state == S_RUN) && din_valid) begin
      history <= window[MAX_LEN-2:0];
      if (match) begin
        match_count <= cnt_next;
        fill        <= overlap ? fill_inc : '0;
      end else begin
        fill <= fill_inc;
      end
    end
  end

`ifdef DETECT_REG_EN
  logic detect_q;

  // Registered detect: one cycle after the matching bit, dropped on abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        detect_q <= 1'b0;
    else if (abort_go) detect_q <= 1'b0;
    else               detect_q <= match;
  end

  assign detect = detect_q;
`else
  assign detect = match;
`endif

endmodule
